// File: rtl/regfile_wb_arbiter.sv
// Two-source round-robin arbiter with burst locking for the register-file write port.
// Optional lock watchdog enabled by defining REGARB_LOCK_TIMEOUT_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_reg,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_last,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_reg,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_last,
  output logic              WE,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              grant_id,
  output logic              lock_abort
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic                grant_id_q, grant_id_d;
  logic                lock_abort_q, lock_abort_d;

  logic                acc_any;
  logic                acc_src;
  logic [ADDR_W-1:0]   acc_reg;
  logic [DATA_W-1:0]   acc_data;
  logic                acc_last;

`ifdef REGARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  always_comb begin
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    case (state_q)
      LOCK0:   s0_ready = s0_valid;
      LOCK1:   s1_ready = s1_valid;
      default: begin
        s0_ready = s0_valid && (!s1_valid || !rr_ptr_q);
        s1_ready = s1_valid && (!s0_valid || rr_ptr_q);
      end
    endcase
  end

  // At most one ready is ever high, so the accepted beat is a simple mux on source 1.
  assign acc_src  = s1_valid && s1_ready;
  assign acc_any  = (s0_valid && s0_ready) || acc_src;
  assign acc_reg  = acc_src ? s1_reg  : s0_reg;
  assign acc_data = acc_src ? s1_data : s0_data;
  assign acc_last = acc_src ? s1_last : s0_last;

  always_comb begin
    we_d         = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    grant_id_d   = grant_id_q;
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_abort_d = 1'b0;
`ifdef REGARB_LOCK_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    if (acc_any) begin
      // Register 0 is hardwired: the beat is consumed but never written.
      we_d         = |acc_reg;
      write_reg_d  = acc_reg;
      write_data_d = acc_data;
      grant_id_d   = acc_src;
      if (acc_last) begin
        state_d  = IDLE;
        rr_ptr_d = ~acc_src;
      end else if (state_q == IDLE) begin
        state_d = acc_src ? LOCK1 : LOCK0;
      end
    end

`ifdef REGARB_LOCK_TIMEOUT_EN
    if (acc_any) begin
      cnt_d = '0;
    end else if (state_q != IDLE) begin
      if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
        state_d      = IDLE;
        rr_ptr_d     = (state_q == LOCK0);
        lock_abort_d = 1'b1;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      we_q         <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      grant_id_q   <= 1'b0;
      lock_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      we_q         <= we_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      grant_id_q   <= grant_id_d;
      lock_abort_q <= lock_abort_d;
    end
  end

`ifdef REGARB_LOCK_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign WE         = we_q;
  assign WriteReg   = write_reg_q;
  assign WriteData  = write_data_q;
  assign grant_id   = grant_id_q;
  assign lock_abort = lock_abort_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter against a transaction-level model.
module tb_regfile_wb_arbiter;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int LOCK_TIMEOUT = 15;

  logic              clk;
  logic              rst;
  logic              s0_valid, s1_valid;
  logic              s0_ready, s1_ready;
  logic [ADDR_W-1:0] s0_reg, s1_reg;
  logic [DATA_W-1:0] s0_data, s1_data;
  logic              s0_last, s1_last;
  logic              WE;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              grant_id;
  logic              lock_abort;

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the port (-1 nobody), whose turn it is, and expected outputs.
  int                m_owner, m_rr, m_bub;
  logic              m_we, m_gid, m_abort;
  logic [ADDR_W-1:0] m_reg;
  logic [DATA_W-1:0] m_data;
  bit                acc0, acc1;

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_reg(s0_reg), .s0_data(s0_data), .s0_last(s0_last),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_reg(s1_reg), .s1_data(s1_data), .s1_last(s1_last),
    .WE(WE), .WriteReg(WriteReg), .WriteData(WriteData), .grant_id(grant_id), .lock_abort(lock_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_bub = 0;
    m_we = 1'b0; m_gid = 1'b0; m_abort = 1'b0; m_reg = '0; m_data = '0;
    acc0 = 1'b0; acc1 = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".WE"},         WE,         m_we);
    check({tag, ".WriteReg"},   WriteReg,   m_reg);
    check({tag, ".WriteData"},  WriteData,  m_data);
    check({tag, ".grant_id"},   grant_id,   m_gid);
    check({tag, ".lock_abort"}, lock_abort, m_abort);
  endtask

  task automatic drv(input int k, input bit v, input int r, input logic [DATA_W-1:0] d, input bit l);
    if (k == 0) begin
      s0_valid = v; s0_reg = ADDR_W'(r); s0_data = d; s0_last = l;
    end else begin
      s1_valid = v; s1_reg = ADDR_W'(r); s1_data = d; s1_last = l;
    end
  endtask

  // One clock: check readies against the model, clock, then check registered outputs.
  task automatic step(input string tag);
    bit r0, r1, lst;
    int k;
    logic [ADDR_W-1:0] rg;
    logic [DATA_W-1:0] dt;
    #1;
    if (m_owner == 0) begin
      r0 = s0_valid; r1 = 1'b0;
    end else if (m_owner == 1) begin
      r0 = 1'b0; r1 = s1_valid;
    end else if (s0_valid && s1_valid) begin
      r0 = (m_rr == 0); r1 = (m_rr == 1);
    end else begin
      r0 = s0_valid; r1 = s1_valid;
    end
    check({tag, ".s0_ready"}, s0_ready, r0);
    check({tag, ".s1_ready"}, s1_ready, r1);
    acc0 = s0_valid && r0;
    acc1 = s1_valid && r1;
    k   = acc1 ? 1 : 0;
    rg  = acc1 ? s1_reg  : s0_reg;
    dt  = acc1 ? s1_data : s0_data;
    lst = acc1 ? s1_last : s0_last;
    @(posedge clk);
    #1;
    m_abort = 1'b0;
    if (acc0 || acc1) begin
      m_we = (rg != 0); m_reg = rg; m_data = dt; m_gid = k[0]; m_bub = 0;
      if (lst) begin
        m_owner = -1; m_rr = 1 - k;
      end else begin
        m_owner = k;
      end
    end else begin
      m_we = 1'b0;
`ifdef REGARB_LOCK_TIMEOUT_EN
      if (m_owner != -1) begin
        m_bub++;
        if (m_bub == LOCK_TIMEOUT) begin
          m_rr = 1 - m_owner; m_owner = -1; m_abort = 1'b1; m_bub = 0;
        end
      end
`endif
    end
    check_outputs(tag);
  endtask

  task automatic gen(input int k);
    drv(k, $urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom, $urandom_range(0, 2) != 0);
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    model_reset();
    #3;
    check_outputs("reset");
    check("reset.s0_ready", s0_ready, 1'b0);
    check("reset.s1_ready", s1_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single beat from source 0.
    drv(0, 1, 3, 32'hDEADBEEF, 1);
    step("single");
    check("single.data_const", WriteData, 32'hDEADBEEF);
    check("single.reg_const", WriteReg, 5'd3);
    drv(0, 0, 3, 32'hDEADBEEF, 1);
    step("single_idle");
    check("single_idle.we_const", WE, 1'b0);

    // Asynchronous reset in the middle of a lock.
    drv(0, 1, 7, 32'h55, 0);
    step("pre_rst");
    #2 rst = 1'b1;
    #1;
    drv(0, 0, 0, 0, 0);
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;

    // Fairness with both sources continuously valid.
    drv(0, 1, 1, 32'h1111, 1);
    drv(1, 1, 2, 32'h2222, 1);
    for (int i = 0; i < 4; i++) begin
      step("alternate");
      check("alternate.gid_seq", grant_id, i[0]);
      check("alternate.reg_seq", WriteReg, i[0] ? 5'd2 : 5'd1);
    end

    // Make source 1 preferred, then a locked burst with two bubbles.
    drv(1, 0, 0, 0, 0);
    step("prefer1");
    drv(1, 1, 4, 32'h44, 0);
    step("burst4");
    drv(1, 1, 5, 32'h55, 0);
    step("burst5");
    drv(1, 0, 5, 32'h55, 0);
    step("bubble_a");
    check("bubble_a.s0_blocked", WE, 1'b0);
    step("bubble_b");
    drv(1, 1, 6, 32'h66, 1);
    step("burst6");
    check("burst6.reg_const", WriteReg, 5'd6);
    drv(1, 0, 0, 0, 0);
    step("after_burst");
    check("after_burst.gid_const", grant_id, 1'b0);

    // Register 0 beat is consumed without a write and still advances the turn.
    drv(0, 1, 0, 32'h1234, 1);
    step("reg0");
    check("reg0.we_const", WE, 1'b0);
    drv(0, 1, 1, 32'hAAAA, 1);
    drv(1, 1, 2, 32'hBBBB, 1);
    step("reg0_next");
    check("reg0_next.gid_const", grant_id, 1'b1);

    // Lock held by source 0 while it stalls and source 1 waits.
    drv(1, 0, 0, 0, 0);
    step("drain");
    drv(0, 1, 8, 32'h88, 0);
    step("lock_open");
    drv(0, 0, 8, 32'h88, 0);
    drv(1, 1, 9, 32'h99, 1);
    for (int i = 0; i < LOCK_TIMEOUT; i++) begin
      step("stall");
    end
`ifdef REGARB_LOCK_TIMEOUT_EN
    check("stall.abort_const", lock_abort, 1'b1);
`else
    check("stall.abort_const", lock_abort, 1'b0);
`endif
    drv(0, 1, 10, 32'hA0, 1);
    step("stall_end");
    if (!s0_valid || acc0) drv(0, 0, 0, 0, 0);
    if (acc1) drv(1, 0, 0, 0, 0);
    step("stall_end2");

    // Randomized traffic; sources hold a beat until it is accepted.
    for (int i = 0; i < 400; i++) begin
      if (!s0_valid || acc0) gen(0);
      if (!s1_valid || acc1) gen(1);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (write enable, write register, write data) between two writeback requesters.
- Typical requesters: source 0 = ALU/execute writeback, source 1 = load/multi-cycle unit.
- Round-robin arbitration with burst locking, so a multi-register transaction (e.g. load-multiple) completes uninterrupted.
- Output is registered and drives the register file directly; the register file commits on the following negedge.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register index width.
- LOCK_TIMEOUT, 15, consecutive bubble cycles tolerated inside a lock (used only with optional feature).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- s0_valid  in  1  source 0 beat valid.
- s0_ready  out  1  source 0 beat accepted this cycle (combinational).
- s0_reg  in  ADDR_W  source 0 destination register.
- s0_data  in  DATA_W  source 0 write data.
- s0_last  in  1  source 0 final beat of transaction.
- s1_valid, s1_ready, s1_reg, s1_data, s1_last  as source 0, for source 1.
- WE  out  1  register-file write enable (registered).
- WriteReg  out  ADDR_W  register-file write index (registered).
- WriteData  out  DATA_W  register-file write data (registered).
- grant_id  out  1  source of the beat currently on the output (registered).
- lock_abort  out  1  one-cycle pulse on lock timeout (optional feature only; tied 0 otherwise).

Behaviour:
- Reset: asynchronous, active-high, on rst.
  - State=IDLE, rr_ptr=0 (source 0 preferred), WE=0, WriteReg=0, WriteData=0, grant_id=0, lock_abort=0, timeout counter=0.
  - Reset mid-burst returns to IDLE. An unaccepted beat is not written.
- Handshake: a beat transfers on posedge when sX_valid && sX_ready.
  - Source must hold valid/reg/data/last stable until accepted.
  - At most one ready is high per cycle.
- Output latency: accepted beat appears on WE/WriteReg/WriteData/grant_id at the same posedge. The register file commits at the next negedge, so data is readable from the second half of that cycle.
- Output update per posedge:
  - No accept: WE=0; WriteReg/WriteData hold their previous values.
  - Accepted beat with reg==0: WE=0, WriteReg=0, WriteData=data. The beat still counts for last/lock/rr purposes.
- States: IDLE, LOCK0, LOCK1.
  - IDLE, ready logic:
    - Only one source valid: that source gets ready.
    - Both valid: source rr_ptr gets ready.
  - IDLE, on an accepted beat:
    - last=1: stay IDLE; rr_ptr <= other source.
    - last=0: go to LOCKx, where x = accepted source; rr_ptr unchanged.
  - LOCKx:
    - sX_ready = sX_valid; the other source's ready = 0.
    - sX_valid low is a bubble: WE=0, stay LOCKx.
    - Accepted beat with last=1: go to IDLE; rr_ptr <= other source.
- Fairness: with both sources continuously valid and single-beat transactions, grants strictly alternate 0,1,0,1…
- No ordering or hazard checks between sources. Same-register writes from both sources commit in grant order.

Optional Feature:
- Macro: REGARB_LOCK_TIMEOUT_EN
- Defined:
  - In LOCKx, a counter increments on each bubble cycle and clears on each accepted beat.
  - When the counter reaches LOCK_TIMEOUT bubbles: force IDLE at that posedge, rr_ptr <= other source, lock_abort=1 for one cycle, counter=0.
  - Partial writes already committed are not undone.
- Not defined: no counter; lock held indefinitely; lock_abort constant 0.

Test Plan:
- Reset then idle, rst pulsed high mid-cycle -> all outputs 0 immediately; s0_ready=s1_ready=0 with no valids.
- s0 alone, reg=3, data=0xDEADBEEF, last=1 -> s0_ready=1; next posedge WE=1, WriteReg=3, WriteData=0xDEADBEEF, grant_id=0; following cycle WE=0.
- Both valid continuously, single beats, s0 reg=1, s1 reg=2, after reset -> output sequence reg 1,2,1,2 with grant_id 0,1,0,1.
- s1 burst of 3 beats to regs 4,5,6 (last on 6), with s0 valid throughout and s1 dropping valid for 2 cycles mid-burst -> s0_ready=0 until reg6 accepted; WE=0 during bubbles; s0 granted on the next cycle.
- s0 writes reg=0, data=0x1234, last=1 -> accepted, WE=0; rr_ptr advances, so s1 is granted next when both are valid.
- With REGARB_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=15: s0 sends last=0 then drops valid for 15 cycles -> lock_abort pulses once, state returns to IDLE, s1 (valid) granted next cycle. Without the macro -> s1_ready stays 0.
